// File: rtl/flags_ctrl_pkg.sv
// Shared constants for the flags register controller: flag bit positions,
// jump-condition select positions and FSM state encoding.
package flags_ctrl_pkg;

  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_LT = 1;
  localparam int unsigned FLAG_C  = 0;

  localparam int unsigned JZ  = 2;
  localparam int unsigned JLT = 1;
  localparam int unsigned JGT = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/flags_cond.sv
// Combinational jump-condition evaluator: {Z,LT,C} flags and {jz,jlt,jgt}
// select to a single taken bit. Shared with the branch unit.
module flags_cond
  import flags_ctrl_pkg::*;
(
  input  logic [2:0] i_flags,
  input  logic [2:0] i_cond_sel,
  output logic       o_taken_d
);

  always_comb begin
    o_taken_d = (i_flags[FLAG_Z]  & i_cond_sel[JZ])  |
                (i_flags[FLAG_LT] & i_cond_sel[JLT]) |
                (~i_flags[FLAG_Z] & ~i_flags[FLAG_LT] & i_cond_sel[JGT]);
  end

endmodule

// File: rtl/flags_ctrl.sv
// Arbitrates ALU flag updates and bus flag restores onto the 3-bit FR, keeps a
// shadow copy of the FR and evaluates jump conditions against it.
module flags_ctrl
  import flags_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          BUS_PRIO = 1'b1
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             alu_req,
  input  logic [WIDTH-1:0] alu_val,
  input  logic             alu_carry,
  output logic             alu_ack,
  input  logic             bus_req,
  input  logic [2:0]       bus_flags,
  output logic             bus_ack,
  output logic [2:0]       fr_in,
  output logic             fr_load_bar,
  output logic [2:0]       flags,
  output logic             busy,
  input  logic             cond_valid,
  input  logic [2:0]       cond_sel,
  output logic             taken,
  output logic             taken_valid
);

  state_t     r_state;
  logic [2:0] r_fr_in;
  logic [2:0] r_flags;
  logic       r_fr_load_bar;
  logic       r_alu_ack;
  logic       r_bus_ack;
  logic       r_busy;
  logic       r_taken;
  logic       r_taken_valid;

  logic       w_bus_wins;
  logic [2:0] w_alu_flags;
  logic [2:0] w_cond_src;
  logic       w_taken_d;

  always_comb begin
    w_bus_wins           = bus_req & (BUS_PRIO | ~alu_req);
    w_alu_flags          = '0;
    w_alu_flags[FLAG_Z]  = (alu_val == '0);
    w_alu_flags[FLAG_LT] = alu_val[WIDTH-1];
    w_alu_flags[FLAG_C]  = alu_carry;
    // Forward the value being loaded so a condition in LOAD sees the new flags.
    w_cond_src           = (r_state == ST_LOAD) ? r_fr_in : r_flags;
  end

  flags_cond u_cond (
    .i_flags    (w_cond_src),
    .i_cond_sel (cond_sel),
    .o_taken_d  (w_taken_d)
  );

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state       <= ST_INIT;
      r_fr_in       <= '0;
      r_flags       <= '0;
      r_fr_load_bar <= 1'b1;
      r_alu_ack     <= 1'b0;
      r_bus_ack     <= 1'b0;
      r_busy        <= 1'b1;
      r_taken       <= 1'b0;
      r_taken_valid <= 1'b0;
    end else begin
      r_taken_valid <= cond_valid;
      if (cond_valid) r_taken <= w_taken_d;
      case (r_state)
        // Load strobe is registered, so INIT spends one edge raising it and
        // a second edge (the FR clear) dropping it again.
        ST_INIT: begin
          if (r_fr_load_bar) begin
            r_fr_in       <= '0;
            r_fr_load_bar <= 1'b0;
          end else begin
            r_fr_load_bar <= 1'b1;
            r_flags       <= '0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (alu_req | bus_req) begin
            r_fr_in       <= w_bus_wins ? bus_flags : w_alu_flags;
            r_fr_load_bar <= 1'b0;
            r_bus_ack     <= w_bus_wins;
            r_alu_ack     <= ~w_bus_wins;
            r_busy        <= 1'b1;
            r_state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_flags       <= r_fr_in;
          r_fr_load_bar <= 1'b1;
          r_alu_ack     <= 1'b0;
          r_bus_ack     <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_fr_load_bar <= 1'b1;
          r_alu_ack     <= 1'b0;
          r_bus_ack     <= 1'b0;
          r_busy        <= 1'b1;
          r_state       <= ST_INIT;
        end
      endcase
    end
  end

  assign fr_in       = r_fr_in;
  assign fr_load_bar = r_fr_load_bar;
  assign flags       = r_flags;
  assign alu_ack     = r_alu_ack;
  assign bus_ack     = r_bus_ack;
  assign busy        = r_busy;
  assign taken       = r_taken;
  assign taken_valid = r_taken_valid;

endmodule

// File: tb/tb_flags_ctrl.sv
// Directed bench for flags_ctrl with a behavioural FR; a bus-priority and an
// ALU-priority instance run side by side.
module tb_flags_ctrl;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic        alu_req, bus_req, alu_req0, bus_req0;
  logic [15:0] alu_val;
  logic        alu_carry;
  logic [2:0]  bus_flags;
  logic        cond_valid;
  logic [2:0]  cond_sel;

  logic        alu_ack, bus_ack, fr_load_bar, busy, taken, taken_valid;
  logic [2:0]  fr_in, flags;
  logic        alu_ack0, bus_ack0, fr_load_bar0, busy0, taken0, taken_valid0;
  logic [2:0]  fr_in0, flags0;

  logic [2:0]  fr_q = 3'bxxx;
  logic        mon = 1'b0;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  flags_ctrl #(.WIDTH(16), .BUS_PRIO(1'b1)) dut (
    .clk(clk), .reset_bar(reset_bar),
    .alu_req(alu_req), .alu_val(alu_val), .alu_carry(alu_carry), .alu_ack(alu_ack),
    .bus_req(bus_req), .bus_flags(bus_flags), .bus_ack(bus_ack),
    .fr_in(fr_in), .fr_load_bar(fr_load_bar), .flags(flags), .busy(busy),
    .cond_valid(cond_valid), .cond_sel(cond_sel), .taken(taken), .taken_valid(taken_valid)
  );

  flags_ctrl #(.WIDTH(16), .BUS_PRIO(1'b0)) dut0 (
    .clk(clk), .reset_bar(reset_bar),
    .alu_req(alu_req0), .alu_val(alu_val), .alu_carry(alu_carry), .alu_ack(alu_ack0),
    .bus_req(bus_req0), .bus_flags(bus_flags), .bus_ack(bus_ack0),
    .fr_in(fr_in0), .fr_load_bar(fr_load_bar0), .flags(flags0), .busy(busy0),
    .cond_valid(cond_valid), .cond_sel(cond_sel), .taken(taken0), .taken_valid(taken_valid0)
  );

  // Behavioural flags register driven by the controller
  always @(posedge clk) if (!fr_load_bar) fr_q <= fr_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      chk("fr_eq_flags", {13'd0, fr_q}, {13'd0, flags});
      chk("ack_excl", {15'd0, alu_ack & bus_ack}, 16'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ALU update on the bus-priority instance: ack one cycle after req
  task automatic alu_txn(input logic [15:0] val, input logic c, input logic [2:0] exp, input string tag);
    alu_val = val; alu_carry = c; alu_req = 1'b1;
    step();
    chk({tag, "_ack"}, {15'd0, alu_ack}, 16'd1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
    step();
    alu_req = 1'b0;
    chk({tag, "_flags"}, {13'd0, flags}, {13'd0, exp});
    chk({tag, "_fr"}, {13'd0, fr_q}, {13'd0, exp});
  endtask

  task automatic cond_txn(input logic [2:0] sel, input logic exp, input string tag);
    cond_valid = 1'b1; cond_sel = sel;
    step();
    cond_valid = 1'b0;
    chk({tag, "_tv"}, {15'd0, taken_valid}, 16'd1);
    chk({tag, "_taken"}, {15'd0, taken}, {15'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_bar = 1'b0; alu_req = 1'b0; bus_req = 1'b0; alu_req0 = 1'b0; bus_req0 = 1'b0;
    alu_val = '0; alu_carry = 1'b0; bus_flags = '0; cond_valid = 1'b0; cond_sel = '0;
    step(); step();
    chk("rst_lb", {15'd0, fr_load_bar}, 16'd1);
    chk("rst_fr_in", {13'd0, fr_in}, 16'd0);
    chk("rst_flags", {13'd0, flags}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd1);
    chk("rst_acks", {14'd0, alu_ack, bus_ack}, 16'd0);
    chk("rst_taken", {14'd0, taken, taken_valid}, 16'd0);
    reset_bar = 1'b1;

    // 1: INIT clears the FR, then idle
    step();
    chk("init_lb", {15'd0, fr_load_bar}, 16'd0);
    chk("init_fr_in", {13'd0, fr_in}, 16'd0);
    chk("init_busy", {15'd0, busy}, 16'd1);
    step();
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_lb", {15'd0, fr_load_bar}, 16'd1);
    chk("init_fr", {13'd0, fr_q}, 16'd0);
    chk("init_flags", {13'd0, flags}, 16'd0);
    mon = 1'b1;

    // 2: ALU updates
    alu_txn(16'h0000, 1'b1, 3'b101, "alu_zero");
    alu_txn(16'h8000, 1'b0, 3'b010, "alu_neg");

    // 3: simultaneous requests on both priority settings
    alu_val = 16'h0001; alu_carry = 1'b0; bus_flags = 3'b011;
    alu_req = 1'b1; bus_req = 1'b1; alu_req0 = 1'b1; bus_req0 = 1'b1;
    step();
    chk("p1_first_bus", {14'd0, bus_ack, alu_ack}, 16'b10);
    chk("p0_first_alu", {14'd0, bus_ack0, alu_ack0}, 16'b01);
    step();
    bus_req = 1'b0; alu_req0 = 1'b0;
    chk("p1_flags_bus", {13'd0, flags}, 16'd3);
    chk("p0_flags_alu", {13'd0, flags0}, 16'd0);
    chk("p1_gap", {14'd0, bus_ack, alu_ack}, 16'd0);
    step();
    chk("p1_second_alu", {14'd0, bus_ack, alu_ack}, 16'b01);
    chk("p0_second_bus", {14'd0, bus_ack0, alu_ack0}, 16'b10);
    step();
    alu_req = 1'b0; bus_req0 = 1'b0;
    chk("p1_flags_alu", {13'd0, flags}, 16'd0);
    chk("p0_flags_bus", {13'd0, flags0}, 16'd3);

    // 4: condition evaluation
    alu_txn(16'h0000, 1'b0, 3'b100, "alu_z");
    cond_txn(3'b100, 1'b1, "jz_z1");
    step();
    chk("tv_pulse", {15'd0, taken_valid}, 16'd0);
    cond_txn(3'b001, 1'b0, "jgt_z1");
    alu_txn(16'h0001, 1'b0, 3'b000, "alu_pos");
    cond_txn(3'b001, 1'b1, "jgt_pos");
    cond_txn(3'b000, 1'b0, "none_sel");

    // 5: forwarding during LOAD, no forwarding while arbitrating in IDLE
    alu_txn(16'h0000, 1'b0, 3'b100, "alu_z2");
    alu_val = 16'h8000; alu_req = 1'b1;
    step();
    chk("fwd_ack", {15'd0, alu_ack}, 16'd1);
    cond_valid = 1'b1; cond_sel = 3'b010;
    step();
    alu_req = 1'b0; cond_valid = 1'b0;
    chk("fwd_taken", {15'd0, taken}, 16'd1);
    chk("fwd_flags", {13'd0, flags}, 16'd2);
    alu_val = 16'h0000; alu_req = 1'b1; cond_valid = 1'b1; cond_sel = 3'b100;
    step();
    cond_valid = 1'b0;
    chk("nofwd_taken", {15'd0, taken}, 16'd0);
    step();
    alu_req = 1'b0;
    chk("nofwd_flags", {13'd0, flags}, 16'd4);

    // 6: reset during LOAD
    alu_val = 16'h8000; alu_req = 1'b1;
    step();
    chk("mid_ack", {15'd0, alu_ack}, 16'd1);
    mon = 1'b0;
    #2 reset_bar = 1'b0;
    #1;
    chk("abort_lb", {15'd0, fr_load_bar}, 16'd1);
    chk("abort_ack", {15'd0, alu_ack}, 16'd0);
    step();
    reset_bar = 1'b1;
    step();
    chk("reinit_lb", {15'd0, fr_load_bar}, 16'd0);
    chk("reinit_ack", {15'd0, alu_ack}, 16'd0);
    step();
    chk("reinit_fr", {13'd0, fr_q}, 16'd0);
    chk("reinit_flags", {13'd0, flags}, 16'd0);
    mon = 1'b1;
    step();
    chk("held_ack", {15'd0, alu_ack}, 16'd1);
    step();
    alu_req = 1'b0;
    chk("held_flags", {13'd0, flags}, 16'd2);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
